// File: rtl/lfsr_rng_gen.sv
// lfsr_rng_gen: Fibonacci LFSR random source with tick divider, valid/ready handshake,
// sticky overrun flag and step counter. Define LFSR_ZERO_GUARD_EN to recover from an all-zero LFSR.
module lfsr_rng_gen #(
    parameter int              WIDTH    = 10,
    parameter logic [WIDTH-1:0] TAPS    = 10'h240,
    parameter int              TICK_DIV = 100_000_000,
    parameter int              SIG_BITS = 2,
    parameter logic [WIDTH-1:0] SEED    = 10'd13,
    parameter int              CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_value,
    input  logic                rnd_ready,
    output logic [WIDTH-1:0]    rnd,
    output logic [SIG_BITS-1:0] sig,
    output logic                rnd_valid,
    output logic                overrun,
    output logic [CNT_BITS-1:0] count
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [WIDTH-1:0]  lfsr;
    logic [TICK_W-1:0] tick;
    logic              step;

    function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] cur);
`ifdef LFSR_ZERO_GUARD_EN
        if (cur == '0) return SEED;
`endif
        return {cur[WIDTH-2:0], ^(cur & TAPS)};
    endfunction

    function automatic logic [WIDTH-1:0] seed_filter(input logic [WIDTH-1:0] val);
`ifdef LFSR_ZERO_GUARD_EN
        return (val == '0) ? SEED : val;
`else
        return val;
`endif
    endfunction

    assign step = enable && (tick == TICK_LAST);

    // rnd and sig are direct views of the LFSR register, so they stay registered outputs
    assign rnd = lfsr;
    assign sig = lfsr[WIDTH-1 -: SIG_BITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr      <= SEED;
            tick      <= '0;
            count     <= '0;
            rnd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (seed_load) begin
            lfsr      <= seed_filter(seed_value);
            tick      <= '0;
            count     <= '0;
            rnd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (enable) begin
                tick <= step ? '0 : tick + 1'b1;
            end
            if (step) begin
                lfsr      <= lfsr_advance(lfsr);
                count     <= count + 1'b1;
                rnd_valid <= 1'b1;
                // An acceptance in the same cycle consumes the old sample, so no overrun then
                if (rnd_valid && !rnd_ready) overrun <= 1'b1;
            end else if (rnd_valid && rnd_ready) begin
                rnd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Testbench for lfsr_rng_gen: constant vector table, hand-written corner sequences and
// randomized stimulus checked every cycle against an arithmetic reference model.
module tb_lfsr_rng_gen;

    localparam int W  = 10;
    localparam int TD = 4;
    localparam int SB = 2;
    localparam int CB = 16;
    localparam logic [W-1:0] TP = 10'h240;
    localparam logic [W-1:0] SD = 10'd13;
`ifdef LFSR_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, enable, seed_load, rnd_ready;
    logic [W-1:0]  seed_value;
    logic [W-1:0]  rnd;
    logic [SB-1:0] sig;
    logic          rnd_valid, overrun;
    logic [CB-1:0] count;

    lfsr_rng_gen #(
        .WIDTH(W), .TAPS(TP), .TICK_DIV(TD), .SIG_BITS(SB), .SEED(SD), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
        .seed_value(seed_value), .rnd_ready(rnd_ready), .rnd(rnd), .sig(sig),
        .rnd_valid(rnd_valid), .overrun(overrun), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int printed = 0;

    // Reference model state: value, enabled cycles since last restart, flags, step count
    int m_lfsr, m_en, m_cnt;
    bit m_valid, m_ovr;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    function automatic int ref_next(input int x);
        int ones;
        if (GUARD && x == 0) return int'(SD);
        ones = 0;
        for (int i = 0; i < W; i++)
            if (((x >> i) % 2 == 1) && ((int'(TP) >> i) % 2 == 1)) ones++;
        return ((x * 2) % (1 << W)) + (ones % 2);
    endfunction

    task automatic model_restart(input int v);
        m_lfsr = v; m_en = 0; m_cnt = 0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic tick_cyc();
        bit fire;
        @(posedge clk);
        if (reset) begin
            model_restart(int'(SD));
        end else if (seed_load) begin
            model_restart((GUARD && seed_value == 0) ? int'(SD) : int'(seed_value));
        end else begin
            fire = enable && ((m_en + 1) % TD == 0);
            if (enable) m_en++;
            if (fire) begin
                if (m_valid && !rnd_ready) m_ovr = 1;
                m_valid = 1;
                m_lfsr  = ref_next(m_lfsr);
                m_cnt   = (m_cnt + 1) % (1 << CB);
            end else if (m_valid && rnd_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("model_rnd", int'(rnd), m_lfsr);
        chk("model_sig", int'(sig), m_lfsr / (1 << (W - SB)));
        chk("model_valid", int'(rnd_valid), int'(m_valid));
        chk("model_overrun", int'(overrun), int'(m_ovr));
        chk("model_count", int'(count), m_cnt);
    endtask

    task automatic run(input int n);
        repeat (n) tick_cyc();
    endtask

    task automatic do_seed(input int v);
        seed_load  = 1'b1;
        seed_value = W'(v);
        tick_cyc();
        seed_load  = 1'b0;
    endtask

    typedef struct {
        int ncyc;
        bit en;
        bit rdy;
        int exp_rnd;
        int exp_cnt;
        bit exp_valid;
        bit exp_ovr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int early, zeros;

        vecs[0] = '{4, 1'b1, 1'b1, 26,  1, 1'b1, 1'b0};
        vecs[1] = '{4, 1'b1, 1'b1, 52,  2, 1'b1, 1'b0};
        vecs[2] = '{4, 1'b1, 1'b1, 104, 3, 1'b1, 1'b0};
        vecs[3] = '{4, 1'b1, 1'b1, 209, 4, 1'b1, 1'b0};

        reset = 1'b1; enable = 1'b0; seed_load = 1'b0; rnd_ready = 1'b0; seed_value = '0;
        model_restart(int'(SD));
        run(2);
        reset = 1'b0;
        chk("reset_rnd", int'(rnd), 13);
        chk("reset_sig", int'(sig), 0);
        chk("reset_valid", int'(rnd_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_count", int'(count), 0);

        // Default sequence from the reset seed
        for (int i = 0; i < 4; i++) begin
            enable = vecs[i].en;
            rnd_ready = vecs[i].rdy;
            run(vecs[i].ncyc);
            chk("vec_rnd", int'(rnd), vecs[i].exp_rnd);
            chk("vec_sig", int'(sig), 0);
            chk("vec_count", int'(count), vecs[i].exp_cnt);
            chk("vec_valid", int'(rnd_valid), int'(vecs[i].exp_valid));
            chk("vec_overrun", int'(overrun), int'(vecs[i].exp_ovr));
        end

        // Unconsumed samples: valid, then overrun, then cleared by seed load
        enable = 1'b1; rnd_ready = 1'b0;
        do_seed(13);
        chk("ovr_seed_rnd", int'(rnd), 13);
        chk("ovr_seed_valid", int'(rnd_valid), 0);
        run(4);
        chk("ovr_first_valid", int'(rnd_valid), 1);
        chk("ovr_first_overrun", int'(overrun), 0);
        chk("ovr_first_rnd", int'(rnd), 26);
        run(4);
        chk("ovr_second_overrun", int'(overrun), 1);
        chk("ovr_second_rnd", int'(rnd), 52);
        do_seed(13);
        chk("ovr_clear_valid", int'(rnd_valid), 0);
        chk("ovr_clear_overrun", int'(overrun), 0);
        chk("ovr_clear_count", int'(count), 0);

        // Step coincident with acceptance of a pending sample
        do_seed(13);
        run(7);
        rnd_ready = 1'b1;
        run(1);
        chk("coinc_valid", int'(rnd_valid), 1);
        chk("coinc_rnd", int'(rnd), 52);
        chk("coinc_overrun", int'(overrun), 0);
        chk("coinc_count", int'(count), 2);

        // Enable low mid-interval holds the tick counter
        do_seed(13);
        run(2);
        enable = 1'b0;
        run(10);
        chk("hold_rnd", int'(rnd), 13);
        chk("hold_count", int'(count), 0);
        enable = 1'b1;
        run(1);
        chk("hold_resume_count", int'(count), 0);
        run(1);
        chk("hold_step_rnd", int'(rnd), 26);
        chk("hold_step_count", int'(count), 1);

        // Reset mid-interval
        run(6);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        chk("midrst_rnd", int'(rnd), 13);
        chk("midrst_count", int'(count), 0);
        chk("midrst_valid", int'(rnd_valid), 0);
        chk("midrst_overrun", int'(overrun), 0);
        run(3);
        chk("midrst_nostep", int'(count), 0);
        run(1);
        chk("midrst_step_rnd", int'(rnd), 26);
        chk("midrst_step_count", int'(count), 1);

        // Zero seed
        rnd_ready = 1'b1;
        do_seed(0);
        if (GUARD) begin
            chk("zero_guard_rnd", int'(rnd), 13);
            run(4);
            chk("zero_guard_step", int'(rnd), 26);
        end else begin
            chk("zero_rnd", int'(rnd), 0);
            run(20);
            chk("zero_steps_rnd", int'(rnd), 0);
            chk("zero_steps_sig", int'(sig), 0);
            chk("zero_steps_count", int'(count), 5);
        end

        // Full period from seed 13
        do_seed(13);
        early = 0; zeros = 0;
        for (int k = 1; k <= 1023; k++) begin
            run(4);
            if (rnd == '0) zeros++;
            if (k < 1023 && int'(rnd) == 13) early++;
        end
        chk("period_rnd", int'(rnd), 13);
        chk("period_count", int'(count), 1023);
        chk("period_early_return", early, 0);
        chk("period_zero_seen", zeros, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            enable     = ($urandom % 4) != 0;
            rnd_ready  = ($urandom % 3) == 0;
            seed_load  = ($urandom % 64) == 0;
            seed_value = (($urandom % 8) == 0) ? '0 : W'($urandom);
            reset      = ($urandom % 250) == 0;
            tick_cyc();
        end
        reset = 1'b0; seed_load = 1'b0;
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
